// File: rtl/carregador_instrucoes.sv
// Boot-path program loader: copies a block of words from the HD word port into
// the instruction memory, one request/acknowledge read and one write strobe per word.
module carregador_instrucoes #(
  parameter int data_size   = 32,
  parameter int memory_size = 11
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   start_in,
  input  logic [memory_size-1:0] src_base_in,
  input  logic [memory_size-1:0] dst_base_in,
  input  logic [memory_size-1:0] word_count_in,
  output logic                   hd_req_out,
  output logic [memory_size-1:0] hd_addr_out,
  input  logic [data_size-1:0]   hd_data_in,
  input  logic                   hd_ack_in,
  output logic                   mem_we_out,
  output logic [memory_size-1:0] mem_addr_out,
  output logic [data_size-1:0]   mem_data_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [memory_size-1:0] words_done_out
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  localparam logic [memory_size-1:0] One = memory_size'(1);

  state_t                 state_q, state_d;
  logic [memory_size-1:0] src_q, src_d;
  logic [memory_size-1:0] dst_q, dst_d;
  logic [memory_size-1:0] cnt_q, cnt_d;
  logic [memory_size-1:0] idx_q, idx_d;
  logic [memory_size-1:0] wdone_q, wdone_d;
  logic [memory_size-1:0] hd_addr_q, hd_addr_d;
  logic [memory_size-1:0] mem_addr_q, mem_addr_d;
  logic [data_size-1:0]   mem_data_q, mem_data_d;
  logic [memory_size-1:0] idx_next;

  assign idx_next = idx_q + One;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdone_d    = wdone_q;
    hd_addr_d  = hd_addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          src_d   = src_base_in;
          dst_d   = dst_base_in;
          cnt_d   = word_count_in;
          idx_d   = '0;
          wdone_d = '0;
          if (word_count_in == '0) begin
            state_d = DONE;
          end else begin
            state_d   = REQ;
            hd_addr_d = src_base_in;
          end
        end
      end
      REQ: begin
        // The HD word goes straight into the write-data register; it only becomes
        // visible as the write cycle begins, so the held-value rule still holds.
        if (hd_ack_in) begin
          mem_data_d = hd_data_in;
          mem_addr_d = dst_q + idx_q;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        idx_d   = idx_next;
        wdone_d = wdone_q + One;
        if (idx_next == cnt_q) begin
          state_d = DONE;
        end else begin
          state_d   = REQ;
          hd_addr_d = src_q + idx_next;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdone_q    <= '0;
      hd_addr_q  <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdone_q    <= wdone_d;
      hd_addr_q  <= hd_addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Strobes are masked during the reset cycle so no write or request escapes it.
  assign hd_req_out     = (state_q == REQ)   && !reset_in;
  assign mem_we_out     = (state_q == WRITE) && !reset_in;
  assign done_out       = (state_q == DONE)  && !reset_in;
  assign busy_out       = (state_q != IDLE)  && !reset_in;
  assign hd_addr_out    = hd_addr_q;
  assign mem_addr_out   = mem_addr_q;
  assign mem_data_out   = mem_data_q;
  assign words_done_out = wdone_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Bench for carregador_instrucoes: HD responder with programmable wait, event
// monitor, and a cycle-level transfer model built from the word/latency rules.
module tb_carregador_instrucoes;

  localparam int DS = 32;
  localparam int MS = 11;
  localparam int AMOD = 1 << MS;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          start_in = 1'b0;
  logic [MS-1:0] src_base_in = '0;
  logic [MS-1:0] dst_base_in = '0;
  logic [MS-1:0] word_count_in = '0;
  logic          hd_req_out;
  logic [MS-1:0] hd_addr_out;
  logic [DS-1:0] hd_data_in = '0;
  logic          hd_ack_in = 1'b0;
  logic          mem_we_out;
  logic [MS-1:0] mem_addr_out;
  logic [DS-1:0] mem_data_out;
  logic          busy_out;
  logic          done_out;
  logic [MS-1:0] words_done_out;

  carregador_instrucoes #(.data_size(DS), .memory_size(MS)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
    .src_base_in(src_base_in), .dst_base_in(dst_base_in), .word_count_in(word_count_in),
    .hd_req_out(hd_req_out), .hd_addr_out(hd_addr_out), .hd_data_in(hd_data_in),
    .hd_ack_in(hd_ack_in), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out), .busy_out(busy_out), .done_out(done_out),
    .words_done_out(words_done_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct packed {
    int          cyc;
    logic [10:0] a;
    logic [31:0] d;
  } ev_t;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  hd_wait = 0;
  logic spur_ack = 1'b0;
  int  wcnt = 0;
  logic busy_prev = 1'b0;

  ev_t obs_wr[$], obs_req[$], obs_done[$], obs_busy[$];
  ev_t exp_wr[$], exp_req[$], exp_done[$], exp_busy[$];

  always @(posedge clock_in) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int c, input int a, input logic [31:0] d);
    ev_t e;
    e.cyc = c;
    e.a   = 11'(a);
    e.d   = d;
    return e;
  endfunction

  // HD side: ack w cycles after the request rises, data = 0xA0000000 + address.
  always @(negedge clock_in) begin
    logic auto_ack;
    auto_ack = 1'b0;
    if (hd_req_out === 1'b1) begin
      if (wcnt == hd_wait) auto_ack = 1'b1;
      wcnt = wcnt + 1;
    end else begin
      wcnt = 0;
    end
    hd_ack_in  = auto_ack | spur_ack;
    hd_data_in = 32'hA000_0000 + 32'(hd_addr_out);
  end

  always @(negedge clock_in) begin
    if (mem_we_out === 1'b1) obs_wr.push_back(mk_ev(cyc, int'(mem_addr_out), mem_data_out));
    if (hd_req_out === 1'b1) obs_req.push_back(mk_ev(cyc, int'(hd_addr_out), 32'd0));
    if (done_out === 1'b1)   obs_done.push_back(mk_ev(cyc, 0, 32'd0));
    if (busy_out !== busy_prev) obs_busy.push_back(mk_ev(cyc, 0, {31'd0, busy_out}));
    busy_prev = busy_out;
  end

  // Transfer model: word i occupies w+1 REQ cycles then one WRITE cycle.
  function automatic void model_xfer(input int k, input int src, input int dst,
                                     input int n, input int w);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j <= w; j++)
        exp_req.push_back(mk_ev(k + 1 + i * (w + 2) + j, (src + i) % AMOD, 32'd0));
      exp_wr.push_back(mk_ev(k + (i + 1) * (w + 2), (dst + i) % AMOD,
                             32'hA000_0000 + 32'((src + i) % AMOD)));
    end
    exp_done.push_back(mk_ev(k + n * (w + 2) + 1, 0, 32'd0));
    exp_busy.push_back(mk_ev(k + 1, 0, 32'd1));
    exp_busy.push_back(mk_ev(k + n * (w + 2) + 2, 0, 32'd0));
  endfunction

  function automatic int qdiff(input ev_t o[$], input ev_t e[$]);
    int m;
    m = (o.size() > e.size()) ? o.size() - e.size() : e.size() - o.size();
    for (int i = 0; i < o.size() && i < e.size(); i++)
      if (o[i] !== e[i]) m++;
    return m;
  endfunction

  task automatic clear_all();
    obs_wr.delete(); obs_req.delete(); obs_done.delete(); obs_busy.delete();
    exp_wr.delete(); exp_req.delete(); exp_done.delete(); exp_busy.delete();
  endtask

  // Call at posedge+#1; returns the edge index k at which start was sampled.
  task automatic start_xfer(input int s, input int d, input int n, output int k);
    src_base_in   = 11'(s);
    dst_base_in   = 11'(d);
    word_count_in = 11'(n);
    start_in      = 1'b1;
    @(posedge clock_in); #1;
    k = cyc - 1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int g;
    g = 0;
    while (obs_done.size() < target && g < 3000) begin
      @(posedge clock_in); #1;
      g++;
    end
    if (obs_done.size() < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done pulses got=%0d want=%0d", nm, obs_done.size(), target);
    end
    @(posedge clock_in); #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (3) @(posedge clock_in);
    #1 reset_in = 1'b0;
    checks++;
    if ({hd_req_out, hd_addr_out, mem_we_out, mem_addr_out, mem_data_out,
         busy_out, done_out, words_done_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b haddr=%0d we=%b maddr=%0d mdata=%h busy=%b done=%b wd=%0d want all 0",
               hd_req_out, hd_addr_out, mem_we_out, mem_addr_out, mem_data_out,
               busy_out, done_out, words_done_out);
    end
  endtask

  task automatic test_basic();
    int k, m;
    clear_all(); hd_wait = 0;
    start_xfer(100, 0, 4, k);
    model_xfer(k, 100, 0, 4, 0);
    wait_done(1, "basic");
    m = qdiff(obs_wr, exp_wr);   checks++;
    if (m !== 0) begin errors++; $display("FAIL basic_writes: %0d mismatches, got %0d writes want %0d", m, obs_wr.size(), exp_wr.size()); end
    m = qdiff(obs_req, exp_req); checks++;
    if (m !== 0) begin errors++; $display("FAIL basic_reqs: %0d mismatches, got %0d req cycles want %0d", m, obs_req.size(), exp_req.size()); end
    m = qdiff(obs_done, exp_done); checks++;
    if (m !== 0) begin errors++; $display("FAIL basic_done: got cycle %0d want %0d", obs_done.size() ? obs_done[0].cyc : -1, k + 9); end
    m = qdiff(obs_busy, exp_busy); checks++;
    if (m !== 0) begin errors++; $display("FAIL basic_busy: %0d mismatches in busy edges", m); end
    checks++;
    if (words_done_out !== 11'd4) begin errors++; $display("FAIL basic_words_done: got %0d want 4", words_done_out); end
  endtask

  task automatic test_wait_states();
    int k, m;
    clear_all(); hd_wait = 3;
    start_xfer(300, 700, 2, k);
    model_xfer(k, 300, 700, 2, 3);
    wait_done(1, "wait");
    m = qdiff(obs_req, exp_req); checks++;
    if (m !== 0) begin errors++; $display("FAIL wait_reqs: %0d mismatches, got %0d req cycles want %0d", m, obs_req.size(), exp_req.size()); end
    m = qdiff(obs_wr, exp_wr);   checks++;
    if (m !== 0) begin errors++; $display("FAIL wait_writes: %0d mismatches, got %0d writes want 2", m, obs_wr.size()); end
    checks++;
    if (obs_done.size() != 1 || obs_done[0].cyc !== k + 11) begin
      errors++; $display("FAIL wait_done: got cycle %0d want %0d", obs_done.size() ? obs_done[0].cyc : -1, k + 11);
    end
    m = qdiff(obs_busy, exp_busy); checks++;
    if (m !== 0) begin errors++; $display("FAIL wait_busy: %0d mismatches in busy edges", m); end
    hd_wait = 0;
  endtask

  task automatic test_count0_spurious();
    int k, m;
    clear_all(); hd_wait = 0; spur_ack = 1'b1;
    repeat (5) begin @(posedge clock_in); #1; end
    checks++;
    if (obs_req.size() + obs_wr.size() + obs_busy.size() + obs_done.size() !== 0) begin
      errors++; $display("FAIL idle_ack: got %0d events while idle want 0",
                         obs_req.size() + obs_wr.size() + obs_busy.size() + obs_done.size());
    end
    clear_all();
    start_xfer(55, 66, 0, k);
    model_xfer(k, 55, 66, 0, 0);
    wait_done(1, "count0");
    checks++;
    if (obs_req.size() + obs_wr.size() !== 0) begin
      errors++; $display("FAIL count0_activity: got %0d req/write cycles want 0", obs_req.size() + obs_wr.size());
    end
    m = qdiff(obs_done, exp_done); checks++;
    if (m !== 0) begin errors++; $display("FAIL count0_done: got cycle %0d want %0d", obs_done.size() ? obs_done[0].cyc : -1, k + 1); end
    m = qdiff(obs_busy, exp_busy); checks++;
    if (m !== 0) begin errors++; $display("FAIL count0_busy: %0d mismatches in busy edges", m); end
    checks++;
    if (words_done_out !== 11'd0) begin errors++; $display("FAIL count0_words_done: got %0d want 0", words_done_out); end
    // Ack held high through every state, including WRITE.
    clear_all();
    start_xfer(10, 20, 3, k);
    model_xfer(k, 10, 20, 3, 0);
    wait_done(1, "ackhigh");
    spur_ack = 1'b0;
    m = qdiff(obs_wr, exp_wr); checks++;
    if (m !== 0) begin errors++; $display("FAIL ackhigh_writes: %0d mismatches, got %0d writes want 3", m, obs_wr.size()); end
    m = qdiff(obs_done, exp_done); checks++;
    if (m !== 0) begin errors++; $display("FAIL ackhigh_done: %0d mismatches", m); end
  endtask

  task automatic test_wrap();
    int k, m;
    clear_all(); hd_wait = 1;
    start_xfer(2046, 2047, 3, k);
    model_xfer(k, 2046, 2047, 3, 1);
    wait_done(1, "wrap");
    m = qdiff(obs_req, exp_req); checks++;
    if (m !== 0) begin errors++; $display("FAIL wrap_hd_addr: %0d mismatches, first got %0d want 2046", m, obs_req.size() ? int'(obs_req[0].a) : -1); end
    m = qdiff(obs_wr, exp_wr); checks++;
    if (m !== 0) begin errors++; $display("FAIL wrap_mem_addr: %0d mismatches, last got %0d want 1", m, obs_wr.size() ? int'(obs_wr[obs_wr.size()-1].a) : -1); end
    m = qdiff(obs_done, exp_done); checks++;
    if (m !== 0) begin errors++; $display("FAIL wrap_done: %0d mismatches", m); end
    hd_wait = 0;
  endtask

  task automatic test_reset_mid();
    int k, m, g;
    clear_all(); hd_wait = 0;
    start_xfer(400, 800, 8, k);
    g = 0;
    while (obs_wr.size() < 2 && g < 100) begin @(posedge clock_in); #1; g++; end
    checks++;
    if (hd_req_out !== 1'b1) begin errors++; $display("FAIL midreset_in_req: got req=%b want 1", hd_req_out); end
    reset_in = 1'b1;
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    checks++;
    if ({hd_req_out, hd_addr_out, mem_we_out, mem_addr_out, mem_data_out,
         busy_out, done_out, words_done_out} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got req=%b haddr=%0d we=%b maddr=%0d mdata=%h busy=%b done=%b wd=%0d want all 0",
               hd_req_out, hd_addr_out, mem_we_out, mem_addr_out, mem_data_out,
               busy_out, done_out, words_done_out);
    end
    checks++;
    if (obs_wr.size() !== 2) begin errors++; $display("FAIL midreset_writes: got %0d writes want 2", obs_wr.size()); end
    clear_all();
    repeat (6) begin @(posedge clock_in); #1; end
    checks++;
    if (obs_done.size() + obs_wr.size() + obs_req.size() !== 0) begin
      errors++; $display("FAIL midreset_abandon: got %0d events after reset want 0", obs_done.size() + obs_wr.size() + obs_req.size());
    end
    clear_all();
    start_xfer(5, 9, 1, k);
    model_xfer(k, 5, 9, 1, 0);
    wait_done(1, "after_reset");
    m = qdiff(obs_wr, exp_wr) + qdiff(obs_done, exp_done) + qdiff(obs_req, exp_req); checks++;
    if (m !== 0) begin errors++; $display("FAIL after_reset_xfer: %0d mismatches", m); end
    checks++;
    if (words_done_out !== 11'd1) begin errors++; $display("FAIL after_reset_words_done: got %0d want 1", words_done_out); end
  endtask

  task automatic test_back_to_back();
    int k1, k2, m, g;
    clear_all(); hd_wait = 1;
    start_xfer(1000, 1500, 4, k1);
    model_xfer(k1, 1000, 1500, 4, 1);
    for (int i = 0; i < 10; i++) begin
      src_base_in   = 11'($urandom_range(0, AMOD - 1));
      dst_base_in   = 11'($urandom_range(0, AMOD - 1));
      word_count_in = 11'($urandom_range(1, 9));
      start_in      = 1'b1;
      @(posedge clock_in); #1;
    end
    start_in = 1'b0;
    g = 0;
    while (obs_done.size() < 1 && g < 100) begin @(posedge clock_in); #1; g++; end
    start_xfer(30, 40, 3, k2);
    checks++;
    if (k2 !== k1 + 14) begin errors++; $display("FAIL b2b_accept: start accepted at edge %0d want %0d", k2 - k1, 14); end
    model_xfer(k2, 30, 40, 3, 1);
    wait_done(2, "b2b");
    m = qdiff(obs_wr, exp_wr); checks++;
    if (m !== 0) begin errors++; $display("FAIL b2b_writes: %0d mismatches, got %0d writes want %0d", m, obs_wr.size(), exp_wr.size()); end
    m = qdiff(obs_req, exp_req); checks++;
    if (m !== 0) begin errors++; $display("FAIL b2b_reqs: %0d mismatches", m); end
    m = qdiff(obs_done, exp_done) + qdiff(obs_busy, exp_busy); checks++;
    if (m !== 0) begin errors++; $display("FAIL b2b_done_busy: %0d mismatches", m); end
    checks++;
    if (words_done_out !== 11'd3) begin errors++; $display("FAIL b2b_words_done: got %0d want 3", words_done_out); end
    hd_wait = 0;
  endtask

  task automatic test_random();
    int k, m, s, d, n, w;
    for (int t = 0; t < 6; t++) begin
      s = $urandom_range(0, AMOD - 1);
      d = $urandom_range(0, AMOD - 1);
      n = $urandom_range(1, 10);
      w = $urandom_range(0, 3);
      clear_all(); hd_wait = w;
      start_xfer(s, d, n, k);
      model_xfer(k, s, d, n, w);
      wait_done(1, "random");
      m = qdiff(obs_wr, exp_wr); checks++;
      if (m !== 0) begin errors++; $display("FAIL random%0d_writes: %0d mismatches (src=%0d dst=%0d n=%0d w=%0d)", t, m, s, d, n, w); end
      m = qdiff(obs_req, exp_req) + qdiff(obs_done, exp_done) + qdiff(obs_busy, exp_busy); checks++;
      if (m !== 0) begin errors++; $display("FAIL random%0d_timing: %0d mismatches (n=%0d w=%0d)", t, m, n, w); end
      checks++;
      if (words_done_out !== 11'(n)) begin errors++; $display("FAIL random%0d_words_done: got %0d want %0d", t, words_done_out, n); end
    end
    hd_wait = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_count0_spurious();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
